// File: rtl/lock_pkg.sv
// lock_pkg
// Shared definitions for the keypad lock controller: key code constants,
// the controller state encoding and a digit classification helper.
package lock_pkg;

  // Keypad function keys; codes 0000-1001 are the digits 0-9 and
  // 1100-1111 are treated as invalid presses.
  localparam logic [3:0] KEY_STAR = 4'b1010;
  localparam logic [3:0] KEY_HASH = 4'b1011;

  typedef enum logic [2:0] {
    S_LOCKED,
    S_OPEN,
    S_SAVE_NEW,
    S_SAVE_CONFIRM,
    S_ALARM
  } lock_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/code_entry_buf.sv
// code_entry_buf
// Collects keypad digits into a shift buffer of PW_LEN nibbles. The first
// digit entered ends up in the most significant nibble once the buffer is
// full. Digits arriving while full are dropped and latch the overflow flag.
//
// Ports:
//   clk          system clock
//   reset_1      synchronous active-low reset
//   clear        empties the buffer, count and overflow (wins over shift_en)
//   shift_en     accept 'digit' this cycle
//   digit        4-bit digit value
//   buffer       collected digits, PW_LEN*4 bits
//   entry_count  number of digits currently held
//   overflow     set when a digit arrived while the buffer was full
module code_entry_buf
  import lock_pkg::*;
#(
  parameter int PW_LEN = 4
) (
  input  logic                clk,
  input  logic                reset_1,
  input  logic                clear,
  input  logic                shift_en,
  input  logic [3:0]          digit,
  output logic [PW_LEN*4-1:0] buffer,
  output logic [2:0]          entry_count,
  output logic                overflow
);

  localparam int W = PW_LEN * 4;

  // Zero-extended digit so the shift works for any PW_LEN, including 1.
  logic [W-1:0] digit_ext;
  assign digit_ext = W'(digit);

  always_ff @(posedge clk) begin
    if (!reset_1 || clear) begin
      buffer      <= '0;
      entry_count <= 3'd0;
      overflow    <= 1'b0;
    end else if (shift_en) begin
      if (entry_count < 3'(PW_LEN)) begin
        buffer      <= (buffer << 4) | digit_ext;
        entry_count <= entry_count + 3'd1;
      end else begin
        overflow    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/lock_sequencer.sv
// lock_sequencer
// Keypad-driven lock controller. Sequences LOCKED / OPEN / SAVE / ALARM
// modes, compares entered codes with the stored password, owns password
// storage and drives the lock indicator outputs (all registered).
//
// Ports:
//   clk          system clock
//   reset_1      synchronous active-low reset
//   Code_1       key code (0-9 digits, 1010 '*', 1011 '#', others invalid)
//   Valid_1      one-cycle strobe qualifying Code_1
//   OPEN         lock released
//   LOCK         lock engaged, always the inverse of OPEN
//   SAVE_LIGHT   password-change mode indicator
//   ALARM        lockout active
//   entry_count  digits currently buffered
//   tries_left   remaining wrong attempts before the alarm
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int                   PW_LEN         = 4,
  parameter int                   MAX_TRIES      = 3,
  parameter int                   OPEN_CYCLES    = 1000,
  parameter int                   LOCKOUT_CYCLES = 5000,
  parameter logic [PW_LEN*4-1:0]  DEFAULT_PW     = 16'h1234
) (
  input  logic       clk,
  input  logic       reset_1,
  input  logic [3:0] Code_1,
  input  logic       Valid_1,
  output logic       OPEN,
  output logic       LOCK,
  output logic       SAVE_LIGHT,
  output logic       ALARM,
  output logic [2:0] entry_count,
  output logic [2:0] tries_left
);

  localparam int W    = PW_LEN * 4;
  localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  // Terminal timer values: the transition happens on the cycle the timer
  // already holds this value, giving exactly N cycles in the mode.
  localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCKOUT_CYCLES - 1);

  lock_state_t   state, next_state;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    tries_q, tries_d;
  logic [W-1:0]  pw_q;
  logic [W-1:0]  temp_q;

  logic          buf_clear, buf_shift, temp_load, pw_commit;
  logic [W-1:0]  buf_word;
  logic          buf_ovf;
  logic          key_digit, key_star, key_hash, key_any;
  logic          buf_full, match_pw, match_temp;

  code_entry_buf #(.PW_LEN(PW_LEN)) u_entry (
    .clk         (clk),
    .reset_1     (reset_1),
    .clear       (buf_clear),
    .shift_en    (buf_shift),
    .digit       (Code_1),
    .buffer      (buf_word),
    .entry_count (entry_count),
    .overflow    (buf_ovf)
  );

  assign key_digit = Valid_1 && is_digit(Code_1);
  assign key_star  = Valid_1 && (Code_1 == KEY_STAR);
  assign key_hash  = Valid_1 && (Code_1 == KEY_HASH);
  assign key_any   = key_digit || key_star || key_hash;

  // '#' judges the buffer as it stood before this cycle's update.
  assign buf_full   = (entry_count == 3'(PW_LEN)) && !buf_ovf;
  assign match_pw   = buf_full && (buf_word == pw_q);
  assign match_temp = buf_full && (buf_word == temp_q);

  assign tries_left = tries_q;

  always_ff @(posedge clk) begin
    if (!reset_1) begin
      state      <= S_LOCKED;
      timer_q    <= '0;
      tries_q    <= 3'(MAX_TRIES);
      pw_q       <= DEFAULT_PW;
      temp_q     <= '0;
      OPEN       <= 1'b0;
      LOCK       <= 1'b1;
      SAVE_LIGHT <= 1'b0;
      ALARM      <= 1'b0;
    end else begin
      state      <= next_state;
      timer_q    <= timer_d;
      tries_q    <= tries_d;
      if (temp_load) temp_q <= buf_word;
      if (pw_commit) pw_q   <= temp_q;
      OPEN       <= (next_state == S_OPEN);
      LOCK       <= (next_state != S_OPEN);
      SAVE_LIGHT <= (next_state == S_SAVE_NEW) || (next_state == S_SAVE_CONFIRM);
      ALARM      <= (next_state == S_ALARM);
    end
  end

  always_comb begin
    next_state = state;
    timer_d    = '0;
    tries_d    = tries_q;
    buf_clear  = 1'b0;
    buf_shift  = 1'b0;
    temp_load  = 1'b0;
    pw_commit  = 1'b0;

    unique case (state)
      S_LOCKED: begin
        buf_shift = key_digit;
        buf_clear = key_star || key_hash;
        if (key_hash) begin
          if (match_pw) begin
            next_state = S_OPEN;
            tries_d    = 3'(MAX_TRIES);
          end else if (tries_q <= 3'd1) begin
            next_state = S_ALARM;
            tries_d    = 3'd0;
          end else begin
            tries_d    = tries_q - 3'd1;
          end
        end
      end

      // Any valid key restarts the idle timer; a key also takes priority
      // over a timeout landing on the same cycle.
      S_OPEN: begin
        buf_clear = key_star || key_hash;
        if (key_hash) begin
          next_state = S_LOCKED;
        end else if (key_star) begin
          next_state = S_SAVE_NEW;
        end else if (!key_any) begin
          if (timer_q >= OPEN_LAST) begin
            next_state = S_LOCKED;
          end else begin
            timer_d    = timer_q + 1'b1;
          end
        end
      end

      S_SAVE_NEW: begin
        buf_shift = key_digit;
        buf_clear = key_star || key_hash;
        if (key_star) begin
          next_state = S_LOCKED;
        end else if (key_hash) begin
          if (buf_full) begin
            temp_load  = 1'b1;
            next_state = S_SAVE_CONFIRM;
          end else begin
            next_state = S_LOCKED;
          end
        end
      end

      S_SAVE_CONFIRM: begin
        buf_shift = key_digit;
        buf_clear = key_star || key_hash;
        if (key_star) begin
          next_state = S_LOCKED;
        end else if (key_hash) begin
          pw_commit  = match_temp;
          next_state = S_LOCKED;
        end
      end

      // Keys are ignored and the buffer is held empty for the whole lockout.
      S_ALARM: begin
        buf_clear = 1'b1;
        if (timer_q >= LOCK_LAST) begin
          next_state = S_LOCKED;
          tries_d    = 3'(MAX_TRIES);
        end else begin
          timer_d    = timer_q + 1'b1;
        end
      end

      default: begin
        next_state = S_LOCKED;
      end
    endcase
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer
// Self-checking bench for lock_sequencer. A behavioural model built from
// digit queues and mode/cycle counters predicts every output after every
// clock; directed scenarios are followed by randomized key traffic.
module tb_lock_sequencer;

  localparam int PW_LEN    = 4;
  localparam int MAX_TRIES = 3;
  localparam int OPEN_CYC  = 8;
  localparam int LOCK_CYC  = 16;

  localparam int MD_LOCKED  = 0;
  localparam int MD_OPEN    = 1;
  localparam int MD_SAVE    = 2;
  localparam int MD_CONFIRM = 3;
  localparam int MD_ALARM   = 4;

  logic       clk = 1'b0;
  logic       reset_1 = 1'b0;
  logic       valid_1 = 1'b0;
  logic [3:0] code_1 = 4'd0;
  logic       open_o, lock_o, save_o, alarm_o;
  logic [2:0] count_o, tries_o;

  always #5 clk = ~clk;

  lock_sequencer #(
    .PW_LEN         (PW_LEN),
    .MAX_TRIES      (MAX_TRIES),
    .OPEN_CYCLES    (OPEN_CYC),
    .LOCKOUT_CYCLES (LOCK_CYC),
    .DEFAULT_PW     (16'h1234)
  ) dut (
    .clk         (clk),
    .reset_1     (reset_1),
    .Code_1      (code_1),
    .Valid_1     (valid_1),
    .OPEN        (open_o),
    .LOCK        (lock_o),
    .SAVE_LIGHT  (save_o),
    .ALARM       (alarm_o),
    .entry_count (count_o),
    .tries_left  (tries_o)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  int mode;
  int entry_q[$];
  bit ovf;
  int tries;
  int idle_cycles;
  int alarm_cycles;
  int stored_pw[PW_LEN];
  int temp_pw[PW_LEN];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
    end
  endtask

  function automatic void model_reset();
    mode         = MD_LOCKED;
    entry_q.delete();
    ovf          = 1'b0;
    tries        = MAX_TRIES;
    idle_cycles  = 0;
    alarm_cycles = 0;
    stored_pw    = '{1, 2, 3, 4};
    temp_pw      = '{0, 0, 0, 0};
  endfunction

  function automatic bit entry_equals(input bit use_temp);
    if (entry_q.size() != PW_LEN || ovf) return 1'b0;
    for (int i = 0; i < PW_LEN; i++) begin
      if (entry_q[i] != (use_temp ? temp_pw[i] : stored_pw[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void clear_entry();
    entry_q.delete();
    ovf = 1'b0;
  endfunction

  function automatic void model_step(input bit v, input int c);
    bit dig, star, hash;
    dig  = v && (c <= 9);
    star = v && (c == 10);
    hash = v && (c == 11);
    if (mode == MD_ALARM) begin
      alarm_cycles++;
      if (alarm_cycles == LOCK_CYC) begin
        mode  = MD_LOCKED;
        tries = MAX_TRIES;
      end
    end else if (mode == MD_OPEN) begin
      if (hash) mode = MD_LOCKED;
      else if (star) mode = MD_SAVE;
      else if (dig) idle_cycles = 0;
      else begin
        idle_cycles++;
        if (idle_cycles == OPEN_CYC) mode = MD_LOCKED;
      end
    end else begin
      if (dig) begin
        if (entry_q.size() < PW_LEN) entry_q.push_back(c);
        else ovf = 1'b1;
      end else if (star) begin
        clear_entry();
        mode = MD_LOCKED;
      end else if (hash) begin
        if (mode == MD_LOCKED) begin
          if (entry_equals(1'b0)) begin
            mode        = MD_OPEN;
            idle_cycles = 0;
            tries       = MAX_TRIES;
          end else begin
            tries--;
            if (tries == 0) begin
              mode         = MD_ALARM;
              alarm_cycles = 0;
            end
          end
        end else if (mode == MD_SAVE) begin
          if (entry_q.size() == PW_LEN && !ovf) begin
            for (int i = 0; i < PW_LEN; i++) temp_pw[i] = entry_q[i];
            mode = MD_CONFIRM;
          end else begin
            mode = MD_LOCKED;
          end
        end else begin
          if (entry_equals(1'b1)) stored_pw = temp_pw;
          mode = MD_LOCKED;
        end
        clear_entry();
      end
    end
  endfunction

  task automatic compareAll();
    checkOutput("OPEN", 32'(open_o), 32'(mode == MD_OPEN));
    checkOutput("LOCK", 32'(lock_o), 32'(mode != MD_OPEN));
    checkOutput("SAVE_LIGHT", 32'(save_o), 32'(mode == MD_SAVE || mode == MD_CONFIRM));
    checkOutput("ALARM", 32'(alarm_o), 32'(mode == MD_ALARM));
    checkOutput("entry_count", 32'(count_o), 32'(entry_q.size()));
    checkOutput("tries_left", 32'(tries_o), 32'(tries));
  endtask

  task automatic applyStimulus(input bit v, input int c);
    @(negedge clk);
    valid_1 = v;
    code_1  = 4'(c);
    @(posedge clk);
    model_step(v, c);
    #1;
    compareAll();
  endtask

  task automatic press(input int c);
    applyStimulus(1'b1, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0);
  endtask

  task automatic type4(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_1 = 1'b0;
    valid_1 = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    compareAll();
    @(negedge clk);
    reset_1 = 1'b1;
  endtask

  initial begin
    int sel, n;
    int cur[PW_LEN];
    int nd[PW_LEN];

    model_reset();
    doReset();

    // Correct code opens, idle timeout relocks after exactly 8 cycles
    type4(1, 2, 3, 4); press(11);
    checkOutput("t1_open_after_hash", 32'(open_o), 32'd1);
    idle(7);
    checkOutput("t1_still_open", 32'(open_o), 32'd1);
    idle(1);
    checkOutput("t1_relocked", 32'(lock_o), 32'd1);

    // Three wrong codes trigger the alarm; keys ignored during lockout
    doReset();
    for (int k = 0; k < 3; k++) begin
      type4(1, 2, 3, 5); press(11);
    end
    checkOutput("t2_alarm", 32'(alarm_o), 32'd1);
    checkOutput("t2_tries_zero", 32'(tries_o), 32'd0);
    type4(1, 2, 3, 4); press(11);
    idle(11);
    checkOutput("t2_alarm_cleared", 32'(alarm_o), 32'd0);
    checkOutput("t2_tries_restored", 32'(tries_o), 32'd3);

    // Password change 9876 is committed
    doReset();
    type4(1, 2, 3, 4); press(11);
    press(10);
    type4(9, 8, 7, 6); press(11);
    checkOutput("t3_save_light", 32'(save_o), 32'd1);
    type4(9, 8, 7, 6); press(11);
    checkOutput("t3_save_done", 32'(save_o), 32'd0);
    type4(1, 2, 3, 4); press(11);
    checkOutput("t3_old_pw_rejected", 32'(tries_o), 32'd2);
    type4(9, 8, 7, 6); press(11);
    checkOutput("t3_new_pw_opens", 32'(open_o), 32'd1);

    // Mismatched confirm keeps the old password
    doReset();
    type4(1, 2, 3, 4); press(11);
    press(10);
    type4(9, 8, 7, 6); press(11);
    type4(9, 8, 7, 5); press(11);
    type4(1, 2, 3, 4); press(11);
    checkOutput("t4_old_pw_opens", 32'(open_o), 32'd1);

    // Overflow rejects; '*' recovers a half-typed entry
    doReset();
    type4(1, 2, 3, 4); press(5); press(11);
    checkOutput("t5_overflow_tries", 32'(tries_o), 32'd2);
    press(1); press(2); press(10);
    type4(1, 2, 3, 4); press(11);
    checkOutput("t5_opens", 32'(open_o), 32'd1);

    // Reset in the middle of a confirm discards the pending save
    doReset();
    type4(1, 2, 3, 4); press(11);
    press(10);
    type4(4, 4, 4, 4); press(11);
    press(4); press(4);
    doReset();
    checkOutput("t6_count_cleared", 32'(count_o), 32'd0);
    type4(1, 2, 3, 4); press(11);
    checkOutput("t6_default_opens", 32'(open_o), 32'd1);

    // Randomized traffic against the model
    doReset();
    for (int it = 0; it < 400; it++) begin
      sel = $urandom_range(0, 6);
      case (sel)
        0: begin
          cur = stored_pw;
          for (int i = 0; i < PW_LEN; i++) press(cur[i]);
          press(11);
        end
        1: begin
          n = $urandom_range(0, 6);
          for (int i = 0; i < n; i++) press($urandom_range(0, 9));
          press(11);
        end
        2: press(10);
        3: idle($urandom_range(1, 20));
        4: begin
          for (int i = 0; i < 4; i++) applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 15));
        end
        5: begin
          if (mode == MD_OPEN) begin
            press(10);
            for (int i = 0; i < PW_LEN; i++) nd[i] = $urandom_range(0, 9);
            for (int i = 0; i < PW_LEN; i++) press(nd[i]);
            press(11);
            if ($urandom_range(0, 1) == 1) nd[PW_LEN-1] = (nd[PW_LEN-1] + 1) % 10;
            for (int i = 0; i < PW_LEN; i++) press(nd[i]);
            press(11);
          end else begin
            cur = stored_pw;
            for (int i = 0; i < PW_LEN; i++) press(cur[i]);
            press(11);
          end
        end
        default: begin
          press($urandom_range(0, 9));
          if ($urandom_range(0, 3) == 0) doReset();
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
